// File: rtl/dct_pkg.sv
// Shared constants for the 8-point DCT/IDCT family: sample widths and the
// Q14 cosine coefficients Ci = round(2^14 * 0.5 * cos(i*pi/16)).
package dct_pkg;

    localparam int IN_W      = 8;
    localparam int OUT_W     = 29;
    localparam int COEF_FRAC = 14;

    localparam int C1 = 8035;
    localparam int C2 = 7568;
    localparam int C3 = 6811;
    // C4 doubles as the DC scale, since 0.5*cos(pi/4) == 0.5/sqrt(2)
    localparam int C4 = 5793;
    localparam int C5 = 4551;
    localparam int C6 = 3135;
    localparam int C7 = 1598;

endpackage

// File: rtl/dct_butterfly8.sv
// Combinational input butterfly of the 8-point DCT: mirrored sums/differences
// plus the even-half sums feeding X0/X2/X4/X6.
module dct_butterfly8 #(
    parameter int IN_W = 8
) (
    input  logic signed [IN_W-1:0] x0,
    input  logic signed [IN_W-1:0] x1,
    input  logic signed [IN_W-1:0] x2,
    input  logic signed [IN_W-1:0] x3,
    input  logic signed [IN_W-1:0] x4,
    input  logic signed [IN_W-1:0] x5,
    input  logic signed [IN_W-1:0] x6,
    input  logic signed [IN_W-1:0] x7,
    output logic signed [IN_W:0]   d0,
    output logic signed [IN_W:0]   d1,
    output logic signed [IN_W:0]   d2,
    output logic signed [IN_W:0]   d3,
    output logic signed [IN_W+1:0] e0,
    output logic signed [IN_W+1:0] e1,
    output logic signed [IN_W+1:0] e2,
    output logic signed [IN_W+1:0] e3
);

    localparam int SW = IN_W + 1;
    localparam int EW = IN_W + 2;

    logic signed [SW-1:0] s0, s1, s2, s3;

    assign s0 = SW'(x0) + SW'(x7);
    assign s1 = SW'(x1) + SW'(x6);
    assign s2 = SW'(x2) + SW'(x5);
    assign s3 = SW'(x3) + SW'(x4);

    assign d0 = SW'(x0) - SW'(x7);
    assign d1 = SW'(x1) - SW'(x6);
    assign d2 = SW'(x2) - SW'(x5);
    assign d3 = SW'(x3) - SW'(x4);

    assign e0 = EW'(s0) + EW'(s3);
    assign e1 = EW'(s1) + EW'(s2);
    assign e2 = EW'(s0) - EW'(s3);
    assign e3 = EW'(s1) - EW'(s2);

endmodule

// File: rtl/dct_1d_8pt.sv
// Fully pipelined 8-point 1-D DCT-II, exact integer result scaled by 2^14.
// Four register stages: input, butterfly, constant products, product sums.
module dct_1d_8pt #(
    parameter int IN_W      = dct_pkg::IN_W,
    parameter int OUT_W     = dct_pkg::OUT_W,
    parameter int COEF_FRAC = dct_pkg::COEF_FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  x0,
    input  logic signed [IN_W-1:0]  x1,
    input  logic signed [IN_W-1:0]  x2,
    input  logic signed [IN_W-1:0]  x3,
    input  logic signed [IN_W-1:0]  x4,
    input  logic signed [IN_W-1:0]  x5,
    input  logic signed [IN_W-1:0]  x6,
    input  logic signed [IN_W-1:0]  x7,
    output logic                    r_valid,
    output logic signed [OUT_W-1:0] X0,
    output logic signed [OUT_W-1:0] X1,
    output logic signed [OUT_W-1:0] X2,
    output logic signed [OUT_W-1:0] X3,
    output logic signed [OUT_W-1:0] X4,
    output logic signed [OUT_W-1:0] X5,
    output logic signed [OUT_W-1:0] X6,
    output logic signed [OUT_W-1:0] X7
);

    // Q(COEF_FRAC) constants need COEF_FRAC+1 magnitude bits plus sign.
    localparam int KW = COEF_FRAC + 2;

    function automatic logic signed [OUT_W-1:0] coef(input int c);
        logic signed [KW-1:0] k;
        k    = KW'(c);
        coef = OUT_W'(k);
    endfunction

    localparam logic signed [OUT_W-1:0] K1 = coef(dct_pkg::C1);
    localparam logic signed [OUT_W-1:0] K2 = coef(dct_pkg::C2);
    localparam logic signed [OUT_W-1:0] K3 = coef(dct_pkg::C3);
    localparam logic signed [OUT_W-1:0] K4 = coef(dct_pkg::C4);
    localparam logic signed [OUT_W-1:0] K5 = coef(dct_pkg::C5);
    localparam logic signed [OUT_W-1:0] K6 = coef(dct_pkg::C6);
    localparam logic signed [OUT_W-1:0] K7 = coef(dct_pkg::C7);

    logic signed [IN_W-1:0]  x_p0 [8];
    logic                    vld_p0;
    logic signed [IN_W:0]    bd   [4];
    logic signed [IN_W+1:0]  be   [4];
    logic signed [IN_W:0]    d_p1 [4];
    logic signed [IN_W+1:0]  e_p1 [4];
    logic                    vld_p1;
    logic signed [OUT_W-1:0] dw   [4];
    logic signed [OUT_W-1:0] e2w, e3w, sumw, difw;
    logic signed [OUT_W-1:0] p0_p2, p4_p2;
    logic signed [OUT_W-1:0] p2_p2 [2];
    logic signed [OUT_W-1:0] p6_p2 [2];
    logic signed [OUT_W-1:0] p1_p2 [4];
    logic signed [OUT_W-1:0] p3_p2 [4];
    logic signed [OUT_W-1:0] p5_p2 [4];
    logic signed [OUT_W-1:0] p7_p2 [4];
    logic                    vld_p2;

    // ---- stage 1: input register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) x_p0[i] <= '0;
            vld_p0 <= 1'b0;
        end else begin
            x_p0[0] <= x0;
            x_p0[1] <= x1;
            x_p0[2] <= x2;
            x_p0[3] <= x3;
            x_p0[4] <= x4;
            x_p0[5] <= x5;
            x_p0[6] <= x6;
            x_p0[7] <= x7;
            vld_p0  <= 1'b1;
        end
    end

    dct_butterfly8 #(
        .IN_W(IN_W)
    ) u_butterfly (
        .x0(x_p0[0]), .x1(x_p0[1]), .x2(x_p0[2]), .x3(x_p0[3]),
        .x4(x_p0[4]), .x5(x_p0[5]), .x6(x_p0[6]), .x7(x_p0[7]),
        .d0(bd[0]),   .d1(bd[1]),   .d2(bd[2]),   .d3(bd[3]),
        .e0(be[0]),   .e1(be[1]),   .e2(be[2]),   .e3(be[3])
    );

    // ---- stage 2: butterfly register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                d_p1[i] <= '0;
                e_p1[i] <= '0;
            end
            vld_p1 <= 1'b0;
        end else begin
            d_p1   <= bd;
            e_p1   <= be;
            vld_p1 <= vld_p0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) dw[i] = OUT_W'(d_p1[i]);
        e2w  = OUT_W'(e_p1[2]);
        e3w  = OUT_W'(e_p1[3]);
        sumw = OUT_W'(e_p1[0]) + OUT_W'(e_p1[1]);
        difw = OUT_W'(e_p1[0]) - OUT_W'(e_p1[1]);
    end

    // ---- stage 3: constant products (signs applied in stage 4) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_p2 <= '0;
            p4_p2 <= '0;
            for (int i = 0; i < 2; i++) begin
                p2_p2[i] <= '0;
                p6_p2[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                p1_p2[i] <= '0;
                p3_p2[i] <= '0;
                p5_p2[i] <= '0;
                p7_p2[i] <= '0;
            end
            vld_p2 <= 1'b0;
        end else begin
            p0_p2    <= K4 * sumw;
            p4_p2    <= K4 * difw;
            p2_p2[0] <= K2 * e2w;
            p2_p2[1] <= K6 * e3w;
            p6_p2[0] <= K6 * e2w;
            p6_p2[1] <= K2 * e3w;
            p1_p2[0] <= K1 * dw[0];
            p1_p2[1] <= K3 * dw[1];
            p1_p2[2] <= K5 * dw[2];
            p1_p2[3] <= K7 * dw[3];
            p3_p2[0] <= K3 * dw[0];
            p3_p2[1] <= K7 * dw[1];
            p3_p2[2] <= K1 * dw[2];
            p3_p2[3] <= K5 * dw[3];
            p5_p2[0] <= K5 * dw[0];
            p5_p2[1] <= K1 * dw[1];
            p5_p2[2] <= K7 * dw[2];
            p5_p2[3] <= K3 * dw[3];
            p7_p2[0] <= K7 * dw[0];
            p7_p2[1] <= K5 * dw[1];
            p7_p2[2] <= K3 * dw[2];
            p7_p2[3] <= K1 * dw[3];
            vld_p2   <= vld_p1;
        end
    end

    // ---- stage 4: signed sums into the output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            X0      <= '0;
            X1      <= '0;
            X2      <= '0;
            X3      <= '0;
            X4      <= '0;
            X5      <= '0;
            X6      <= '0;
            X7      <= '0;
            r_valid <= 1'b0;
        end else begin
            X0      <= p0_p2;
            X4      <= p4_p2;
            X2      <= p2_p2[0] + p2_p2[1];
            X6      <= p6_p2[0] - p6_p2[1];
            X1      <= p1_p2[0] + p1_p2[1] + p1_p2[2] + p1_p2[3];
            X3      <= p3_p2[0] - p3_p2[1] - p3_p2[2] - p3_p2[3];
            X5      <= p5_p2[0] - p5_p2[1] + p5_p2[2] + p5_p2[3];
            X7      <= p7_p2[0] - p7_p2[1] + p7_p2[2] - p7_p2[3];
            r_valid <= vld_p2;
        end
    end

endmodule

// File: tb/tb_dct_1d_8pt.sv
// Directed bench for dct_1d_8pt: reference is the direct DCT-II matrix form
// X_k = sum_n x_n * c(k*(2n+1)), with hand-computed values for key vectors.
module tb_dct_1d_8pt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [7:0]  vin [8];
    logic signed [28:0] y   [8];
    logic               r_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int run = 0;
    logic [63:0] hist [0:1023];

    dct_1d_8pt dut (
        .clk(clk), .rst_n(rst_n),
        .x0(vin[0]), .x1(vin[1]), .x2(vin[2]), .x3(vin[3]),
        .x4(vin[4]), .x5(vin[5]), .x6(vin[6]), .x7(vin[7]),
        .r_valid(r_valid),
        .X0(y[0]), .X1(y[1]), .X2(y[2]), .X3(y[3]),
        .X4(y[4]), .X5(y[5]), .X6(y[6]), .X7(y[7])
    );

    function automatic longint cval(input int k, input int n);
        int m;
        longint s;
        longint c;
        if (k == 0) return 64'sd5793;
        m = (k * (2 * n + 1)) % 32;
        if (m > 16) m = 32 - m;
        s = 1;
        if (m > 8) begin
            m = 16 - m;
            s = -1;
        end
        case (m)
            1: c = 8035;
            2: c = 7568;
            3: c = 6811;
            4: c = 5793;
            5: c = 4551;
            6: c = 3135;
            7: c = 1598;
            default: c = 0;
        endcase
        return s * c;
    endfunction

    function automatic longint dct_ref(input logic [63:0] v, input int k);
        longint acc;
        acc = 0;
        for (int n = 0; n < 8; n++)
            acc += longint'($signed(v[8*n +: 8])) * cval(k, n);
        return acc;
    endfunction

    function automatic logic [63:0] pack_vin();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = vin[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        hist[edge_n] = pack_vin();
        if (rst_n) run++;
        else run = 0;
        edge_n++;
        #1;
    endtask

    // Expected state from the scoreboard: zeros until the pipe has refilled.
    task automatic check_state(input string tag);
        logic [63:0] v;
        chk({tag, "/r_valid"}, 29'(r_valid), (run >= 4) ? 29'd1 : 29'd0);
        if (run >= 4) begin
            v = hist[edge_n - 4];
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s/X%0d", tag, k), y[k], 29'(dct_ref(v, k)));
        end else begin
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s/X%0d", tag, k), y[k], 29'd0);
        end
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < 8; i++) vin[i] = 8'(val);
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) vin[i] = 8'($urandom);
    endtask

    int imp [8];
    int mixed [8];

    initial begin
        imp   = '{5793, 8035, 7568, 6811, 5793, 4551, 3135, 1598};
        mixed = '{64, 32, -45, 55, 64, -10, 15, 78};

        // Reset held for three edges with arbitrary inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick();
            check_state("reset");
        end

        // Release; feed mixed, impulse, +127 DC, -128 DC on consecutive edges
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) vin[i] = 8'(mixed[i]);
        tick();
        check_state("fill1");
        set_all(0);
        vin[0] = 8'sd1;
        tick();
        check_state("fill2");
        set_all(127);
        tick();
        check_state("fill3");
        set_all(-128);
        tick();
        check_state("mixed");
        chk("mixed/X0_hand", y[0], 29'(1465629));
        chk("mixed/X4_hand", y[4], 29'(1558317));

        // Streaming: 16 random vectors back to back, then zeros to drain
        for (int i = 0; i < 19; i++) begin
            if (i < 16) set_rand();
            else set_all(0);
            tick();
            check_state($sformatf("stream%0d", i));
            if (i == 0)
                for (int k = 0; k < 8; k++)
                    chk($sformatf("impulse/X%0d_hand", k), y[k], 29'(imp[k]));
            if (i == 1) begin
                chk("dc127/X0_hand", y[0], 29'(5885688));
                for (int k = 1; k < 8; k++)
                    chk($sformatf("dc127/X%0d_hand", k), y[k], 29'd0);
            end
            if (i == 2) begin
                chk("dcm128/X0_hand", y[0], 29'(-5932032));
                for (int k = 1; k < 8; k++)
                    chk($sformatf("dcm128/X%0d_hand", k), y[k], 29'd0);
            end
        end

        // Mid-stream reset for one edge, then refill
        set_rand();
        tick();
        check_state("prerst");
        rst_n = 1'b0;
        set_rand();
        tick();
        check_state("midrst");
        chk("midrst/r_valid_hand", 29'(r_valid), 29'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rand();
            tick();
            check_state($sformatf("refill%0d", i));
            if (i == 2) chk("refill/r_valid_edge3", 29'(r_valid), 29'd0);
            if (i == 3) chk("refill/r_valid_edge4", 29'(r_valid), 29'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dct_1d_8pt.md
Name: dct_1d_8pt

Overview:
- Fully pipelined 8-point 1-D DCT-II on signed 8-bit samples.
- Orthonormal scaling with coefficients in Q14; output is 29-bit signed with no truncation.
- Accepts one 8-sample vector every clock and has no input handshake.
- Row/column building block of the JPEG 2-D DCT path.

Parameters:
- IN_W, 8: input sample width, signed.
- OUT_W, 29: output coefficient width, signed.
- COEF_FRAC, 14: fractional bits of the coefficient constants.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- x0..x7  in  8 each  signed input samples, n=0..7.
- r_valid  out  1  high when X0..X7 hold results of a sampled input vector.
- X0..X7  out  29 each  signed DCT coefficients k=0..7, scaled by 2^14.

Behaviour:
- Reset: synchronous, active-low, one clock domain. On any rising edge with rst_n=0, all pipeline registers, X0..X7 and r_valid are cleared to 0. A mid-operation reset discards in-flight data and the pipeline refills from scratch.
- Coefficients (integer constants): C4=5793, C1=8035, C2=7568, C3=6811, C5=4551, C6=3135, C7=1598.
- Each Ci = round(2^14 * 0.5 * cos(i*pi/16)). Because C4 equals the round of 2^14*0.5/sqrt2, it also serves as the DC scale.
- Stage 1: register x0..x7 on every edge.
- Stage 2, butterfly (9-bit signed): s_n = x_n + x_(7-n); d_n = x_n - x_(7-n), for n=0..3.
- Stage 2, even sums (10-bit): e0 = s0+s3, e1 = s1+s2, e2 = s0-s3, e3 = s1-s2. Register all values.
- Stage 3, multiply by constants (sign-extended) and register the products:
  - X0 = C4*(e0+e1); X4 = C4*(e0-e1).
  - X2 = C2*e2 + C6*e3; X6 = C6*e2 - C2*e3.
  - X1 = C1*d0 + C3*d1 + C5*d2 + C7*d3.
  - X3 = C3*d0 - C7*d1 - C1*d2 - C5*d3.
  - X5 = C5*d0 - C1*d1 + C7*d2 + C3*d3.
  - X7 = C7*d0 - C5*d1 + C3*d2 - C1*d3.
- Stage 4: sum the products and register them into X0..X7.
- Arithmetic: exact integer math with no rounding, shifting or saturation. |X| < 2^23, so the 29-bit result never overflows; the upper bits are sign extension.
- Latency: a vector sampled at rising edge t appears on X0..X7 after edge t+3. Throughput is one vector per clock.
- r_valid: a 4-bit shift register of ones, cleared by reset.
  - Goes high after the 4th rising edge with rst_n=1, which is when the first post-reset sample reaches the output.
  - Stays high until the next reset.
- Inputs held constant: outputs are constant once r_valid=1.

Decomposition:
- Shared package dct_pkg holds the coefficient localparams C1..C7, COEF_FRAC, IN_W and OUT_W. The 2-D DCT and IDCT reuse them.
- One natural sub-module is dct_butterfly8: the combinational s/d/e computation. It may be inlined instead.
- Multiplies are by constants, so shift-add is permitted as long as results are bit-exact.

Test Plan:
- Reset hold: rst_n=0 for 3 edges with arbitrary inputs -> X0..X7=0 and r_valid=0. After rst_n=1, r_valid rises exactly after the 4th edge.
- Mixed vector: x = {64,32,-45,55,64,-10,15,78} -> X0=1465629 and X4=1558317. X1,X2,X3,X5,X6,X7 are compared against the bit-exact integer formulas above.
- Impulse: x0=1, others 0 -> X0..X7 = 5793, 8035, 7568, 6811, 5793, 4551, 3135, 1598.
- DC extremes:
  - All x=127 -> X0=5885688, X1..X7=0.
  - All x=-128 -> X0=-5932032, X1..X7=0.
- Streaming: a new vector every cycle for 16 cycles -> each result appears exactly 3 edges after its sampling edge, with no bubbles.
- Mid-stream reset: rst_n=0 for one edge -> outputs and r_valid go to 0 at that edge. r_valid returns 4 edges after release.
